// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: receiver state encoding, pattern lengths and
// the output beat record.
package maple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START_PAT,
    ST_DATA,
    ST_END_WAIT
  } maple_state_t;

  localparam int START_FALLS = 4;
  localparam int END_FALLS   = 2;
  localparam int BYTE_W      = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } maple_beat_t;

endpackage

// File: rtl/maple_line_sync.sv
// One bus line: synchroniser chain, registered level and registered rise/fall
// pulses. Pulses stay quiet until the line has been seen high after reset.
module maple_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall,
  output logic high_seen
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      fill_q    <= '0;
      level     <= 1'b1;
      rise      <= 1'b0;
      fall      <= 1'b0;
      high_seen <= 1'b0;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, line});
      // fill_q marks when the chain holds real pin samples, not reset ones
      fill_q <= SYNC_STAGES'({fill_q, 1'b1});
      level  <= sync_q[SYNC_STAGES-1];
      if (fill_q[SYNC_STAGES-1] && sync_q[SYNC_STAGES-1]) high_seen <= 1'b1;
      rise <= high_seen && !level && sync_q[SYNC_STAGES-1];
      fall <= high_seen && level && !sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/maple_receiver.sv
// Maple bus receiver: decodes start pattern, data bits and end pattern from
// SDCKA/SDCKB and emits bytes on an AXI4-Stream master with a one-byte holdback.
module maple_receiver
  import maple_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 8,
  parameter int SYNC_STAGES          = 2,
  parameter int TIMEOUT_CYCLES       = 4096
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            SDCKA,
  input  logic                            SDCKB,
  input  logic                            ENABLE,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TSTRB,
  output logic                            M_AXIS_TKEEP,
  output logic                            M_AXIS_TLAST,
  output logic                            RECEIVING,
  output logic                            FRAME_ERROR,
  output logic                            OVERFLOW
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // index 0 = SDCKA, index 1 = SDCKB
  logic [1:0] lvl, rise_raw, fall_raw, seen;

  maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [1:0] (
    .clk       (M_AXIS_ACLK),
    .rst       (M_AXIS_ARESET),
    .line      ({SDCKB, SDCKA}),
    .level     (lvl),
    .rise      (rise_raw),
    .fall      (fall_raw),
    .high_seen (seen)
  );

  logic armed, a_fall, a_rise, b_fall, b_rise, a_lvl, b_lvl, any_edge;
  assign armed    = &seen;
  assign a_fall   = fall_raw[0] && armed;
  assign a_rise   = rise_raw[0] && armed;
  assign b_fall   = fall_raw[1] && armed;
  assign b_rise   = rise_raw[1] && armed;
  assign a_lvl    = lvl[0];
  assign b_lvl    = lvl[1];
  assign any_edge = a_fall || a_rise || b_fall || b_rise;

  maple_state_t      state;
  logic [2:0]        start_cnt;
  logic [2:0]        bit_idx;
  logic              phase_b;
  logic              b_moved;
  logic [BYTE_W-2:0] shreg;
  logic [BYTE_W-1:0] pend;
  logic              pend_valid;
  logic [TW-1:0]     tcnt;
  logic              push_q;
  maple_beat_t       push_beat;

  logic              timeout, sample, end_ok, data_abort, flush;
  logic [BYTE_W-1:0] next_byte;

  assign timeout    = (state != ST_IDLE) && !any_edge && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign sample     = phase_b ? b_fall : a_fall;
  assign next_byte  = {shreg, phase_b ? a_lvl : b_lvl};
  // second SDCKA fall with SDCKB parked low is the end pattern
  assign end_ok     = !b_lvl && !b_moved && (bit_idx == 3'(END_FALLS - 1));
  assign data_abort = (state == ST_DATA) && phase_b && a_fall && !b_fall && !end_ok;
  assign flush      = timeout || data_abort ||
                      ((state == ST_END_WAIT) && (a_fall || b_rise));

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state       <= ST_IDLE;
      start_cnt   <= '0;
      bit_idx     <= '0;
      phase_b     <= 1'b0;
      b_moved     <= 1'b0;
      shreg       <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      tcnt        <= '0;
      FRAME_ERROR <= 1'b0;
      push_q      <= 1'b0;
      push_beat   <= '0;
    end else begin
      FRAME_ERROR <= 1'b0;
      push_q      <= 1'b0;
      if (state == ST_IDLE) tcnt <= '0;
      else if (any_edge)    tcnt <= TW'(1);
      else                  tcnt <= tcnt + TW'(1);
      if (b_rise || b_fall) b_moved <= 1'b1;

      if (timeout) begin
        FRAME_ERROR <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (a_fall && b_lvl && ENABLE) begin
              state     <= ST_START_PAT;
              start_cnt <= '0;
            end
          end
          ST_START_PAT: begin
            if (b_fall && start_cnt != '1) start_cnt <= start_cnt + 3'd1;
            if (a_rise) begin
              if (start_cnt == 3'(START_FALLS)) begin
                state   <= ST_DATA;
                bit_idx <= '0;
                phase_b <= 1'b0;
              end else begin
                FRAME_ERROR <= 1'b1;
                state       <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            if (sample) begin
              shreg   <= next_byte[BYTE_W-2:0];
              bit_idx <= bit_idx + 3'd1;
              phase_b <= !phase_b;
              if (!phase_b) b_moved <= 1'b0;
              if (bit_idx == 3'(BYTE_W - 1)) begin
                pend       <= next_byte;
                pend_valid <= 1'b1;
                if (pend_valid) begin
                  push_q    <= 1'b1;
                  push_beat <= '{data: pend, last: 1'b0};
                end
              end
            end else if (phase_b && a_fall) begin
              if (end_ok) begin
                state <= ST_END_WAIT;
              end else begin
                FRAME_ERROR <= 1'b1;
                state       <= ST_IDLE;
              end
            end
          end
          ST_END_WAIT: begin
            if (a_fall) begin
              FRAME_ERROR <= 1'b1;
              state       <= ST_IDLE;
            end else if (b_rise) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // any frame exit hands over the held byte as the last beat
      if (flush && pend_valid) begin
        push_q     <= 1'b1;
        push_beat  <= '{data: pend, last: 1'b1};
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      OVERFLOW      <= 1'b0;
    end else if (push_q) begin
      if (!M_AXIS_TVALID || M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= push_beat.data;
        M_AXIS_TLAST  <= push_beat.last;
      end else begin
        OVERFLOW <= 1'b1;
      end
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

  assign M_AXIS_TSTRB = 1'b1;
  assign M_AXIS_TKEEP = 1'b1;
  assign RECEIVING    = (state != ST_IDLE);

endmodule

// File: tb/tb_maple_receiver.sv
// Directed bench for maple_receiver: drives Maple bus waveforms, keeps a queue
// of expected beats derived from the bytes sent, and checks every cycle.
module tb_maple_receiver;

  localparam int SYNC = 2;
  localparam int TMO  = 4096;
  localparam int HOLD = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic sdcka = 1'b1, sdckb = 1'b1, enable = 1'b1, tready = 1'b1;
  logic tvalid, tstrb, tkeep, tlast, receiving, frame_error, overflow;
  logic [7:0] tdata;

  int vectors = 0, miscompares = 0;
  int cyc = 0, chg_cyc = 0, err_obs = 0, err_cyc = -1, bitpos = 0;
  logic [8:0] exp_q[$];          // {last, data}
  logic [8:0] obs_q[$];
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maple_receiver #(
    .C_M_AXIS_TDATA_WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .SDCKA(sdcka), .SDCKB(sdckb),
    .ENABLE(enable), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TKEEP(tkeep),
    .M_AXIS_TLAST(tlast), .RECEIVING(receiving), .FRAME_ERROR(frame_error),
    .OVERFLOW(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // per-cycle compare against the expected-beat queue
  initial forever begin
    @(negedge clk); #1;
    if (rst) hold_prev = 1'b0;
    else begin
      check("tstrb_tkeep", {tstrb, tkeep}, 2'b11);
      if (frame_error) begin err_obs++; err_cyc = cyc; end
      if (hold_prev) begin
        check("hold_valid", tvalid, 1'b1);
        check("hold_beat", {tlast, tdata}, hold_val);
      end
      if (tvalid && tready) begin
        obs_q.push_back({tlast, tdata});
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL beat_unexpected: got %h last %b, none expected", tdata, tlast);
        end else check("beat", {tlast, tdata}, exp_q.pop_front());
      end
      hold_prev = tvalid && !tready;
      hold_val  = {tlast, tdata};
    end
  end

  task automatic set_pins(input logic a, input logic b);
    if (a !== sdcka || b !== sdckb) chg_cyc = cyc;
    sdcka = a; sdckb = b;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic start_pat(input int n);
    bitpos = 0;
    set_pins(1, 1);
    set_pins(0, 1);
    for (int i = 0; i < n; i++) begin set_pins(0, 0); set_pins(0, 1); end
    set_pins(1, 1);
  endtask

  task automatic send_bit(input logic v);
    if (bitpos % 2 == 0) begin set_pins(1, sdckb); set_pins(1, v); set_pins(0, v); end
    else begin set_pins(sdcka, 1); set_pins(v, 1); set_pins(v, 0); end
    bitpos++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic end_pat();
    set_pins(1, 0); set_pins(0, 0); set_pins(1, 0); set_pins(0, 0);
    set_pins(1, 0); set_pins(1, 1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic pin_beat(input string name, input int idx, input logic [8:0] v);
    if (idx < obs_q.size()) check(name, obs_q[idx], v);
    else begin
      vectors++; miscompares++;
      $display("FAIL %s: beat %0d never arrived, expected %h", name, idx, v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, tvalid, 1'b0);
    check({tag, "_tdata"}, tdata, 8'h00);
    check({tag, "_tlast"}, tlast, 1'b0);
    check({tag, "_frame_error"}, frame_error, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_receiving"}, receiving, 1'b0);
  endtask

  initial begin
    int e0, n0, fire;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // two-byte frame
    e0 = err_obs; n0 = obs_q.size();
    exp_q.push_back({1'b0, 8'hA5}); exp_q.push_back({1'b1, 8'h3C});
    start_pat(4);
    check("recv_in_frame", receiving, 1'b1);
    send_byte(8'hA5); send_byte(8'h3C); end_pat();
    drain("two_byte_drain");
    check("two_byte_err", err_obs - e0, 0);
    pin_beat("lit_beat0", n0, {1'b0, 8'hA5});
    pin_beat("lit_beat1", n0 + 1, {1'b1, 8'h3C});

    // short start pattern
    e0 = err_obs;
    start_pat(3);
    repeat (10) @(negedge clk);
    check("short_start_err", err_obs - e0, 1);
    check("short_start_recv", receiving, 1'b0);
    drain("short_start_nobeat");

    // bus frozen after 12 bits
    e0 = err_obs; n0 = obs_q.size();
    exp_q.push_back({1'b1, 8'h5A});
    start_pat(4);
    send_byte(8'h5A);
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    fire = chg_cyc + SYNC + 1 + TMO;
    for (int i = 0; i < TMO + 100 && err_obs == e0; i++) @(negedge clk);
    @(negedge clk);
    check("timeout_err", err_obs - e0, 1);
    check("timeout_cycle", err_cyc, fire);
    check("timeout_recv", receiving, 1'b0);
    set_pins(1, 1);
    drain("timeout_drain");
    pin_beat("lit_timeout", n0, {1'b1, 8'h5A});

    // partial byte at end pattern
    e0 = err_obs;
    exp_q.push_back({1'b1, 8'hC3});
    start_pat(4);
    send_byte(8'hC3);
    send_bit(1); send_bit(1); send_bit(0); send_bit(1);
    end_pat();
    drain("partial_drain");
    check("partial_err", err_obs - e0, 1);

    // overflow with TREADY held low
    e0 = err_obs;
    tready = 1'b0;
    start_pat(4);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); end_pat();
    repeat (20) @(negedge clk);
    check("ovf_tvalid", tvalid, 1'b1);
    check("ovf_tdata", tdata, 8'h11);
    check("ovf_tlast", tlast, 1'b0);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_err", err_obs - e0, 0);

    // reset mid-byte, then a clean frame
    start_pat(4);
    send_bit(1); send_bit(1); send_bit(0); send_bit(1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0; tready = 1'b1;
    set_pins(1, 1);
    repeat (10) @(negedge clk);
    e0 = err_obs;
    exp_q.push_back({1'b1, 8'h96});
    start_pat(4); send_byte(8'h96); end_pat();
    drain("post_rst_drain");
    check("post_rst_err", err_obs - e0, 0);

    // ENABLE low at start: ignored
    e0 = err_obs;
    enable = 1'b0;
    start_pat(4);
    check("disabled_recv", receiving, 1'b0);
    send_byte(8'h77); end_pat();
    drain("disabled_nobeat");
    enable = 1'b1;

    // ENABLE dropped mid-frame: still received
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b1, 8'hFE});
    start_pat(4);
    enable = 1'b0;
    send_byte(8'h01); send_byte(8'hFE); end_pat();
    enable = 1'b1;
    drain("enable_mid_drain");
    check("enable_err", err_obs - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
